// File: rtl/retire_bus_arbiter.sv
// Round-robin arbiter for the shared retire/CDB write path, with a registered
// CDB broadcast and an accounting counter for tags dispatched but not yet retired.
module retire_bus_arbiter #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned DSIZE  = 5,
   parameter int unsigned DWIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NREQ-1:0]         Req,
   input  logic [NREQ*DSIZE-1:0]   Req_Tag,
   input  logic [NREQ*DWIDTH-1:0]  Req_Data,
   output logic [NREQ-1:0]         Grant,
   input  logic                    tagFifo_full,
   input  logic                    Disp_Tag_Rd,
   output logic                    CDB_Valid,
   output logic [DSIZE-1:0]        CDB_Tag,
   output logic [DWIDTH-1:0]       CDB_Data,
   output logic [DSIZE-1:0]        RB_Tag,
   output logic                    RB_Tag_Valid,
   output logic [DSIZE:0]          Inflight_Cnt,
   output logic                    Err_Underflow,
   output logic                    Err_Overflow
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = DSIZE + 1;
   localparam logic [CW-1:0] CNT_MAX = {1'b1, {DSIZE{1'b0}}};

   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     idx;
   logic [PW-1:0]     win_idx;
   logic              win_valid;
   logic              grant_en;
   logic [DSIZE-1:0]  win_tag;
   logic [DWIDTH-1:0] win_data;

   // Ascending search from rr_ptr; NREQ is a power of two so PW-bit adds wrap.
   always_comb begin
      idx       = '0;
      win_idx   = '0;
      win_valid = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) begin
         idx = rr_ptr + PW'(i);
         if (!win_valid && Req[idx]) begin
            win_valid = 1'b1;
            win_idx   = idx;
         end
      end
   end

   // A full tag FIFO or reset suppresses the grant for this cycle only.
   always_comb begin
      grant_en = win_valid && !tagFifo_full && !reset;
      Grant    = '0;
      if (grant_en)
         Grant[win_idx] = 1'b1;
      win_tag  = Req_Tag[win_idx*DSIZE +: DSIZE];
      win_data = Req_Data[win_idx*DWIDTH +: DWIDTH];
   end

   // Pointer and CDB broadcast; tag/data hold across idle cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr    <= '0;
         CDB_Valid <= 1'b0;
         CDB_Tag   <= '0;
         CDB_Data  <= '0;
      end else begin
         CDB_Valid <= grant_en;
         if (grant_en) begin
            rr_ptr   <= win_idx + PW'(1);
            CDB_Tag  <= win_tag;
            CDB_Data <= win_data;
         end
      end
   end

   // In-flight accounting: a simultaneous dispatch and retire cancel out.
   always_ff @(posedge clock) begin
      if (reset) begin
         Inflight_Cnt  <= '0;
         Err_Underflow <= 1'b0;
         Err_Overflow  <= 1'b0;
      end else begin
         unique case ({Disp_Tag_Rd, CDB_Valid})
            2'b10: begin
               if (Inflight_Cnt == CNT_MAX)
                  Err_Overflow <= 1'b1;
               else
                  Inflight_Cnt <= Inflight_Cnt + CW'(1);
            end
            2'b01: begin
               if (Inflight_Cnt == '0)
                  Err_Underflow <= 1'b1;
               else
                  Inflight_Cnt <= Inflight_Cnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign RB_Tag       = CDB_Tag;
   assign RB_Tag_Valid = CDB_Valid;

endmodule

// File: tb/tb_retire_bus_arbiter.sv
// Directed bench for retire_bus_arbiter: grant order, CDB latency, full stall,
// in-flight counting with its error flags, and reset during a grant.
module tb_retire_bus_arbiter;

   localparam int unsigned NREQ   = 4;
   localparam int unsigned DSIZE  = 5;
   localparam int unsigned DWIDTH = 32;

   logic                   clock;
   logic                   reset;
   logic [NREQ-1:0]        Req;
   logic [NREQ*DSIZE-1:0]  Req_Tag;
   logic [NREQ*DWIDTH-1:0] Req_Data;
   logic [NREQ-1:0]        Grant;
   logic                   tagFifo_full;
   logic                   Disp_Tag_Rd;
   logic                   CDB_Valid;
   logic [DSIZE-1:0]       CDB_Tag;
   logic [DWIDTH-1:0]      CDB_Data;
   logic [DSIZE-1:0]       RB_Tag;
   logic                   RB_Tag_Valid;
   logic [DSIZE:0]         Inflight_Cnt;
   logic                   Err_Underflow;
   logic                   Err_Overflow;

   int tests;
   int fails;

   retire_bus_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .DWIDTH(DWIDTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .Req          (Req),
      .Req_Tag      (Req_Tag),
      .Req_Data     (Req_Data),
      .Grant        (Grant),
      .tagFifo_full (tagFifo_full),
      .Disp_Tag_Rd  (Disp_Tag_Rd),
      .CDB_Valid    (CDB_Valid),
      .CDB_Tag      (CDB_Tag),
      .CDB_Data     (CDB_Data),
      .RB_Tag       (RB_Tag),
      .RB_Tag_Valid (RB_Tag_Valid),
      .Inflight_Cnt (Inflight_Cnt),
      .Err_Underflow(Err_Underflow),
      .Err_Overflow (Err_Overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] t3_seq [5];
      t3_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      tests = 0;
      fails = 0;
      reset = 1'b1;
      Req = '0;
      Req_Tag = '0;
      Req_Data = '0;
      tagFifo_full = 1'b0;
      Disp_Tag_Rd = 1'b0;

      // T1: reset held two cycles
      tick();
      tick();
      check("t1_cdb_valid", 64'(CDB_Valid), 64'(0));
      check("t1_inflight", 64'(Inflight_Cnt), 64'(0));
      check("t1_grant", 64'(Grant), 64'(0));
      check("t1_err_under", 64'(Err_Underflow), 64'(0));
      check("t1_err_over", 64'(Err_Overflow), 64'(0));
      Req = 4'b1111;
      #1;
      check("t1_grant_in_reset", 64'(Grant), 64'(0));
      Req = '0;
      reset = 1'b0;

      Disp_Tag_Rd = 1'b1;
      repeat (16) tick();
      Disp_Tag_Rd = 1'b0;
      check("pre_t2_count", 64'(Inflight_Cnt), 64'(16));

      // T2: single request, one-cycle latency
      Req_Tag[0 +: DSIZE] = 5'd5;
      Req_Data[0 +: DWIDTH] = 32'hDEADBEEF;
      Req = 4'b0001;
      #1;
      check("t2_grant", 64'(Grant), 64'(4'b0001));
      tick();
      Req = '0;
      check("t2_cdb_valid", 64'(CDB_Valid), 64'(1));
      check("t2_cdb_tag", 64'(CDB_Tag), 64'(5));
      check("t2_cdb_data", 64'(CDB_Data), 64'(32'hDEADBEEF));
      check("t2_rb_valid", 64'(RB_Tag_Valid), 64'(1));
      check("t2_rb_tag", 64'(RB_Tag), 64'(5));
      tick();
      check("t2_cdb_idle", 64'(CDB_Valid), 64'(0));
      check("t2_cdb_tag_hold", 64'(CDB_Tag), 64'(5));
      check("t2_count_dec", 64'(Inflight_Cnt), 64'(15));

      reset = 1'b1;
      tick();
      reset = 1'b0;
      Disp_Tag_Rd = 1'b1;
      repeat (16) tick();
      Disp_Tag_Rd = 1'b0;

      // T3: round-robin rotation with all requesters active
      for (int i = 0; i < int'(NREQ); i++) begin
         Req_Tag[i*DSIZE +: DSIZE] = 5'(i + 1);
         Req_Data[i*DWIDTH +: DWIDTH] = 32'h1000_0000 + 32'(i);
      end
      Req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("t3_grant_%0d", k), 64'(Grant), 64'(t3_seq[k]));
         tick();
      end
      check("t3_cdb_tag", 64'(CDB_Tag), 64'(1));
      check("t3_cdb_data", 64'(CDB_Data), 64'(32'h1000_0000));
      Req = 4'b1010;
      #1;
      check("t3_grant_1010", 64'(Grant), 64'(4'b0010));
      tick();

      // T4: tag FIFO full stalls arbitration without moving the pointer
      Req = 4'b1111;
      tagFifo_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("t4_stall_grant_%0d", k), 64'(Grant), 64'(0));
         tick();
         check($sformatf("t4_stall_cdb_%0d", k), 64'(CDB_Valid), 64'(0));
      end
      tagFifo_full = 1'b0;
      #1;
      check("t4_resume_grant", 64'(Grant), 64'(4'b0100));
      tick();
      check("t4_resume_cdb_valid", 64'(CDB_Valid), 64'(1));
      check("t4_resume_cdb_tag", 64'(CDB_Tag), 64'(3));
      Req = '0;
      tick();
      check("t4_count", 64'(Inflight_Cnt), 64'(9));
      check("t4_no_underflow", 64'(Err_Underflow), 64'(0));

      // T6: reset in the cycle a grant is being offered
      Req = 4'b1111;
      #1;
      check("t6_grant_before", 64'(Grant), 64'(4'b1000));
      reset = 1'b1;
      #1;
      check("t6_grant_in_reset", 64'(Grant), 64'(0));
      tick();
      reset = 1'b0;
      check("t6_cdb_valid", 64'(CDB_Valid), 64'(0));
      check("t6_count", 64'(Inflight_Cnt), 64'(0));
      #1;
      check("t6_first_grant", 64'(Grant), 64'(4'b0001));
      Req = '0;
      tick();

      // T5: in-flight accounting and underflow
      Disp_Tag_Rd = 1'b1;
      repeat (3) tick();
      Disp_Tag_Rd = 1'b0;
      check("t5_count3", 64'(Inflight_Cnt), 64'(3));
      Req_Tag[0 +: DSIZE] = 5'd7;
      Req = 4'b0001;
      tick();
      Req = '0;
      Disp_Tag_Rd = 1'b1;
      tick();
      Disp_Tag_Rd = 1'b0;
      check("t5_both", 64'(Inflight_Cnt), 64'(3));
      Req = 4'b0001;
      repeat (3) tick();
      Req = '0;
      tick();
      check("t5_count0", 64'(Inflight_Cnt), 64'(0));
      check("t5_no_underflow", 64'(Err_Underflow), 64'(0));
      Req = 4'b0001;
      tick();
      Req = '0;
      tick();
      check("t5_underflow_count", 64'(Inflight_Cnt), 64'(0));
      check("t5_underflow_flag", 64'(Err_Underflow), 64'(1));

      // Overflow: count saturates at 2**DSIZE
      Disp_Tag_Rd = 1'b1;
      repeat (32) tick();
      Disp_Tag_Rd = 1'b0;
      check("ovf_full_count", 64'(Inflight_Cnt), 64'(32));
      check("ovf_flag_clear", 64'(Err_Overflow), 64'(0));
      Disp_Tag_Rd = 1'b1;
      tick();
      Disp_Tag_Rd = 1'b0;
      check("ovf_sat_count", 64'(Inflight_Cnt), 64'(32));
      check("ovf_flag_set", 64'(Err_Overflow), 64'(1));
      check("underflow_sticky", 64'(Err_Underflow), 64'(1));

      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("final_err_under", 64'(Err_Underflow), 64'(0));
      check("final_err_over", 64'(Err_Overflow), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
